// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: line synchronizers, glitch filters,
// inhibit / request-to-send handshake, 11-clock frame, acknowledge check and watchdog.
module ps2_host_tx #(
    parameter int FILT        = 8,
    parameter int INHIBIT_CYC = 9600,
    parameter int TIMEOUT_CYC = 1920000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int FW = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYC - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // Index 0 carries the clock line, index 1 the data line.
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_dly_q;
    logic          fall;

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          expire;

    // Frame position k: 0..7 data LSB first, 8 odd parity, 9 stop (always 1).
    function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] k);
        if (k < 4'd8)
            return d[k[2:0]];
        else if (k == 4'd8)
            return p;
        else
            return 1'b1;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            clk_dly_q <= 1'b1;
        end else begin
            sync1_q   <= {ps2_dat_i, ps2_clk_i};
            sync2_q   <= sync1_q;
            clk_dly_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FILT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_dly_q & ~filt_q[0];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            inh_q   <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            inh_q   <= inh_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        bit_d   = bit_q;
        inh_d   = inh_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wd_d    = wd_q;
        if (state_q != IDLE && wd_q != WD_MAX)
            wd_d = wd_q + 1'b1;
        expire = (state_q != IDLE) && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                if (tx_req) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    wd_d    = '0;
                    inh_d   = '0;
                    bit_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST)
                    state_d = RTS;
                else
                    inh_d = inh_q + 1'b1;
            end
            RTS: begin
                if (fall) begin
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The edge that moves past parity presents the stop bit from ACK.
                if (fall) begin
                    if (bit_q == 4'd8) begin
                        bit_d   = 4'd9;
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    done_d  = ~filt_q[1];
                    err_d   = filt_q[1];
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (filt_q == 2'b11)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Watchdog expiry overrides anything the line activity asked for this cycle.
        if (expire) begin
            state_d = IDLE;
            bit_d   = '0;
            done_d  = 1'b0;
            err_d   = (state_q != WAIT_IDLE);
        end
    end

    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = (state_q == RTS) ||
                        ((state_q == SHIFT) && !frame_bit(data_q, par_q, bit_q));
    assign tx_busy    = (state_q != IDLE);
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the captured bits are compared with frames built from the byte and parity rule.
module tb_ps2_host_tx;

    localparam int FILT = 8;
    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int H    = 60;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       glitch  = 1'b0;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req  = 1'b0;
    logic       tx_busy, tx_done, tx_err;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_inh  = 0;

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         gl;
        logic [9:0] frame;
        int         done;
        int         err;
    } vec_t;

    vec_t tbl [6];

    ps2_host_tx #(.FILT(FILT), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    // Open-drain wiring: either side can pull a line low.
    assign ps2_clk_i = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (tx_done)    n_done <= n_done + 1;
        if (tx_err)     n_err  <= n_err + 1;
        if (ps2_clk_oe) n_inh  <= n_inh + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic start_req(input logic [7:0] d);
        @(negedge clk_sys);
        tx_data = d;
        tx_req  = 1'b1;
        @(negedge clk_sys);
        tx_req  = 1'b0;
    endtask

    // Device side: wait for the request-to-send, then generate nfalls clock pulses,
    // sampling the data line late in each low phase.
    task automatic dev_xact(input bit ack, input bit gl, input int nfalls,
                            output logic [10:0] cap, output bit ok);
        int k;
        cap = '1;
        ok  = 1'b1;
        k = 0;
        while (!ps2_clk_oe && k < 50) begin @(negedge clk_sys); k++; end
        if (!ps2_clk_oe) ok = 1'b0;
        k = 0;
        while (ok && !(!ps2_clk_oe && ps2_dat_oe) && k < INH + 50) begin @(negedge clk_sys); k++; end
        if (!(!ps2_clk_oe && ps2_dat_oe)) ok = 1'b0;
        if (ok) begin
            repeat (H) @(negedge clk_sys);
            cap[0] = ps2_dat_i;
            for (int j = 1; j <= nfalls; j++) begin
                dev_clk = 1'b0;
                repeat (H) @(negedge clk_sys);
                if (j <= 10) cap[j] = ps2_dat_i;
                dev_clk = 1'b1;
                if (j == 10 && ack) dev_dat = 1'b0;
                if (j == 11) dev_dat = 1'b1;
                if (gl && j == 5) begin
                    repeat (20) @(negedge clk_sys);
                    glitch = 1'b1;
                    repeat (5) @(negedge clk_sys);
                    glitch  = 1'b0;
                    tx_data = 8'hA5;
                    tx_req  = 1'b1;
                    @(negedge clk_sys);
                    tx_req  = 1'b0;
                    repeat (H - 26) @(negedge clk_sys);
                end else begin
                    repeat (H) @(negedge clk_sys);
                end
            end
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic run_xact(input string nm, input logic [7:0] d, input bit ack, input bit gl,
                            input logic [9:0] exp_frame, input int exp_done, input int exp_err);
        int          d0, e0, i0, k;
        logic [10:0] cap;
        bit          ok;
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        start_req(d);
        chk({nm, " busy_after_req"}, int'(tx_busy), 1);
        dev_xact(ack, gl, 11, cap, ok);
        chk({nm, " device_handshake"}, int'(ok), 1);
        k = 0;
        while (tx_busy && k < 500) begin @(negedge clk_sys); k++; end
        chk({nm, " busy_released"}, int'(tx_busy), 0);
        repeat (2) @(negedge clk_sys);
        chk({nm, " start_bit"}, int'(cap[0]), 0);
        chk({nm, " frame"}, int'(cap[10:1]), int'(exp_frame));
        chk({nm, " done_pulses"}, n_done - d0, exp_done);
        chk({nm, " err_pulses"}, n_err - e0, exp_err);
        chk({nm, " inhibit_cycles"}, n_inh - i0, INH);
        if (gl) begin
            repeat (50) @(negedge clk_sys);
            chk({nm, " req_during_shift_ignored"}, int'(tx_busy), 0);
        end
    endtask

    initial begin
        int          d0, e0, k;
        logic [10:0] cap;
        bit          ok;
        logic [7:0]  rd;
        bit          rack;

        tbl[0] = '{d: 8'hED, ack: 1'b1, gl: 1'b0, frame: 10'h3ED, done: 1, err: 0};
        tbl[1] = '{d: 8'h00, ack: 1'b1, gl: 1'b0, frame: 10'h300, done: 1, err: 0};
        tbl[2] = '{d: 8'hED, ack: 1'b0, gl: 1'b0, frame: 10'h3ED, done: 0, err: 1};
        tbl[3] = '{d: 8'hFF, ack: 1'b1, gl: 1'b0, frame: 10'h3FF, done: 1, err: 0};
        tbl[4] = '{d: 8'h01, ack: 1'b0, gl: 1'b0, frame: 10'h201, done: 0, err: 1};
        tbl[5] = '{d: 8'h55, ack: 1'b1, gl: 1'b1, frame: 10'h355, done: 1, err: 0};

        @(negedge clk_sys);
        chk("reset_outputs", int'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err}), 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("idle_after_reset", int'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err}), 0);

        for (int i = 0; i < 6; i++)
            run_xact($sformatf("vec%0d", i), tbl[i].d, tbl[i].ack, tbl[i].gl,
                     tbl[i].frame, tbl[i].done, tbl[i].err);

        // Device never clocks: watchdog must fire TMO cycles after acceptance.
        d0 = n_done;
        e0 = n_err;
        start_req(8'h12);
        k = 0;
        while (!tx_err && k < TMO + 100) begin @(negedge clk_sys); k++; end
        chk("timeout_latency", k, TMO);
        chk("timeout_lines_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        chk("timeout_busy", int'(tx_busy), 0);
        repeat (5) @(negedge clk_sys);
        chk("timeout_done_pulses", n_done - d0, 0);
        chk("timeout_err_pulses", n_err - e0, 1);

        // Asynchronous reset in the middle of the data bits.
        d0 = n_done;
        e0 = n_err;
        start_req(8'h3C);
        dev_xact(1'b1, 1'b0, 5, cap, ok);
        chk("midreset_handshake", int'(ok), 1);
        chk("midreset_busy_before", int'(tx_busy), 1);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1 chk("midreset_async_outputs", int'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err}), 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("midreset_stays_idle", int'(tx_busy), 0);
        chk("midreset_no_done", n_done - d0, 0);
        chk("midreset_no_err", n_err - e0, 0);
        run_xact("after_reset_F4", 8'hF4, 1'b1, 1'b0, 10'h2F4, 1, 0);

        for (int i = 0; i < 8; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_xact($sformatf("rand%0d_%02h", i, rd), rd, rack, 1'b0, model_frame(rd),
                     rack ? 1 : 0, rack ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter FILT, default 8: number of consecutive clk_sys cycles a synchronized PS/2 line must hold a new level before the filtered copy follows it.
REQ-002 SHALL have parameter INHIBIT_CYC, default 9600: length of the host clock-inhibit phase in clk_sys cycles (100 us at 96 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1920000: transaction watchdog limit in clk_sys cycles (20 ms at 96 MHz).
REQ-004 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ps2_clk_i, input, 1 bit: raw PS/2 clock line level, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_dat_i, input, 1 bit: raw PS/2 data line level, asynchronous to clk_sys.
REQ-008 SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls the PS/2 clock line low, 0 releases it.
REQ-009 SHALL have port ps2_dat_oe, output, 1 bit: 1 pulls the PS/2 data line low, 0 releases it.
REQ-010 SHALL have port tx_data, input, 8 bits: command byte to send to the keyboard.
REQ-011 SHALL have port tx_req, input, 1 bit: request to send tx_data.
REQ-012 SHALL have port tx_busy, output, 1 bit: a transaction is in progress.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse when the device acknowledges the byte.
REQ-014 SHALL have port tx_err, output, 1 bit: one-cycle pulse on a missing acknowledge or a watchdog expiry.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_dat_i through 2-flop synchronizers, then through the FILT glitch filter; filtered lines reset to 1.
REQ-016 SHALL define a falling edge as filtered clock 1 -> 0, detected in the cycle after the filter changes.
REQ-017 SHALL implement the states IDLE, INHIBIT, RTS, SHIFT, ACK and WAIT_IDLE.
REQ-018 IDLE: lines released and tx_busy=0; when tx_req=1, SHALL latch tx_data, compute odd parity (~^tx_data), clear the watchdog and enter INHIBIT on the next cycle.
REQ-019 SHALL ignore tx_req in every state other than IDLE; no queueing.
REQ-020 INHIBIT: ps2_clk_oe=1 and ps2_dat_oe=0 for exactly INHIBIT_CYC cycles, then enter RTS.
REQ-021 RTS: ps2_dat_oe=1 (start bit 0) and ps2_clk_oe=0; on the first falling edge, enter SHIFT with bit index 0.
REQ-022 SHIFT, on each falling edge: drive frame bit k, where k=0..7 are data bits (LSB first), k=8 is parity and k=9 is stop (line released).
REQ-023 For each SHIFT bit, ps2_dat_oe SHALL equal the inverted bit value, changing only in the cycle after a falling edge.
REQ-024 After the falling edge that drives the stop bit, SHALL enter ACK.
REQ-025 ACK: on the next falling edge, SHALL sample filtered data; 0 -> pulse tx_done, 1 -> pulse tx_err; then enter WAIT_IDLE.
REQ-026 WAIT_IDLE: lines released; SHALL return to IDLE once filtered clock and data are both 1.
REQ-027 tx_busy SHALL be 1 in every state other than IDLE.
REQ-028 tx_done and tx_err SHALL be mutually exclusive, each at most one pulse per transaction.
REQ-029 The watchdog SHALL count every busy cycle; reaching TIMEOUT_CYC in INHIBIT, RTS, SHIFT or ACK SHALL release both lines, pulse tx_err and enter IDLE.
REQ-030 Reaching TIMEOUT_CYC in WAIT_IDLE SHALL return to IDLE without tx_err.
REQ-031 A falling edge in the same cycle as watchdog expiry SHALL be ignored; the timeout wins.
REQ-032 The bit counter SHALL be 4 bits and SHALL never exceed 9; the watchdog SHALL saturate and never wrap.

Reset
REQ-033 reset_n=0 SHALL immediately and asynchronously force ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_err=0, state IDLE, all counters 0 and filtered lines 1.
REQ-034 Reset asserted mid-transaction SHALL abort the frame with no tx_done or tx_err pulse; after release, the block SHALL wait in IDLE for a new tx_req.

Verification
REQ-035 tx_data=0xED with a device model that ACKs -> ps2_clk_oe high for 9600 cycles; data bits 1,0,1,1,0,1,1,1 then parity 1 and stop released; one tx_done pulse; tx_busy returns to 0.
REQ-036 tx_data=0x00 -> all eight data bits drive ps2_dat_oe=1, parity bit releases the line (parity=1), tx_done pulses.
REQ-037 Device holds data high at the ACK edge -> tx_err pulses once, no tx_done, block returns to IDLE.
REQ-038 Device never clocks after RTS -> tx_err exactly TIMEOUT_CYC cycles after acceptance, both lines released.
REQ-039 reset_n pulsed low after the 4th data bit -> outputs 0 asynchronously, no pulses; a new tx_req of 0xF4 then completes normally with tx_done.
REQ-040 A 5-cycle low glitch on ps2_clk_i during SHIFT (FILT=8) -> no bit advance, frame completes correctly with tx_done; a tx_req pulse during SHIFT is ignored.
